// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and defaults for the interval timer
//
// Purpose: state encoding and default widths used by interval_timer_ctrl and
// timer_count_core. No ports.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH_DEF      = 32;
  localparam int unsigned TIMER_PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    TS_IDLE  = 2'd0,
    TS_RUN   = 2'd1,
    TS_PAUSE = 2'd2,
    TS_DONE  = 2'd3
  } timer_state_e;

  // Plain 2-bit constants so the FSM register stays a flat logic vector.
  localparam logic [1:0] ST_IDLE  = TS_IDLE;
  localparam logic [1:0] ST_RUN   = TS_RUN;
  localparam logic [1:0] ST_PAUSE = TS_PAUSE;
  localparam logic [1:0] ST_DONE  = TS_DONE;

endpackage

// File: rtl/timer_count_core.sv
// rtl/timer_count_core.sv - WIDTH-bit up-counter with sync clear and enable
//
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset (count -> 0)
//   clear_i   in   synchronous clear, wins over enable
//   enable_i  in   increment by one (modulo 2^WIDTH)
//   count_o   out  current count
module timer_count_core
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/interval_timer_ctrl.sv
// rtl/interval_timer_ctrl.sv - interval timer controller (FSM, shadow period, irq)
//
// Optional build macro: INTERVAL_TIMER_PRESCALE_EN adds cfg_prescale and a
// RUN-only prescaler; without it every RUN cycle is a counting tick.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   cfg_load            pulse: capture cfg_period/cfg_periodic into shadow regs
//   cfg_period [WIDTH]  terminal period P (expiry every P ticks)
//   cfg_periodic        1 = auto-reload, 0 = one-shot
//   cfg_prescale [PW]   (macro only) tick every cfg_prescale+1 RUN cycles
//   start/pause/stop    command pulses, priority stop > start > pause
//   irq_clr             pulse: clear sticky irq (an expiry in the same cycle wins)
//   count [WIDTH]       current count
//   state [2]           IDLE=0 RUN=1 PAUSE=2 DONE=3
//   busy                RUN or PAUSE
//   expired             one-cycle pulse per expiry
//   irq                 sticky expiry flag
module interval_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH      = TIMER_WIDTH_DEF,
  parameter int unsigned PRESCALE_W = TIMER_PRESCALE_W_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_load,
  input  logic [WIDTH-1:0]      cfg_period,
  input  logic                  cfg_periodic,
`ifdef INTERVAL_TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] cfg_prescale,
`endif
  input  logic                  start,
  input  logic                  pause,
  input  logic                  stop,
  input  logic                  irq_clr,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  expired,
  output logic                  irq
);

  logic [1:0]            state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  expired_q;
  logic                  irq_q, irq_d;
  logic [WIDTH-1:0]      shadow_period_q;
  logic                  shadow_periodic_q;
  logic [WIDTH-1:0]      active_period_q, active_period_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] prescale_val;
  logic                  cnt_clear;
  logic                  cnt_enable;
  logic                  expire;
  logic                  run_tick;
  logic                  at_term;

`ifdef INTERVAL_TIMER_PRESCALE_EN
  assign prescale_val = cfg_prescale;
`else
  // Divide-by-one: pre_q never leaves zero, so every RUN cycle ticks.
  assign prescale_val = '0;
`endif

  timer_count_core #(.WIDTH(WIDTH)) u_count (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_enable),
    .count_o  (count)
  );

  assign run_tick = (state_q == ST_RUN) && (pre_q == prescale_val);
  // Compare against P-1 so count never goes past it, even for P = 2^WIDTH-1.
  assign at_term  = (count == (active_period_q - WIDTH'(1)));

  always_comb begin
    state_d         = state_q;
    active_period_d = active_period_q;
    pre_d           = pre_q;
    cnt_clear       = 1'b0;
    cnt_enable      = 1'b0;
    expire          = 1'b0;

    if (stop) begin
      state_d   = ST_IDLE;
      cnt_clear = 1'b1;
      pre_d     = '0;
    end else if (start && (state_q != ST_RUN)) begin
      if (state_q == ST_PAUSE) begin
        state_d = ST_RUN;
      end else if (shadow_period_q != '0) begin
        state_d         = ST_RUN;
        active_period_d = shadow_period_q;
        cnt_clear       = 1'b1;
        pre_d           = '0;
      end
    end else if (pause && !start && (state_q == ST_RUN)) begin
      state_d = ST_PAUSE;
    end else if (state_q == ST_RUN) begin
      if (run_tick) begin
        pre_d = '0;
        if (at_term) begin
          expire = 1'b1;
          // Mode is read live so a cfg_load of periodic applies at this decision.
          if (shadow_periodic_q) begin
            cnt_clear       = 1'b1;
            active_period_d = shadow_period_q;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end else begin
        pre_d = pre_q + PRESCALE_W'(1);
      end
    end

    irq_d  = expire ? 1'b1 : (irq_clr ? 1'b0 : irq_q);
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      busy_q            <= 1'b0;
      expired_q         <= 1'b0;
      irq_q             <= 1'b0;
      shadow_period_q   <= '0;
      shadow_periodic_q <= 1'b0;
      active_period_q   <= '0;
      pre_q             <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      expired_q       <= expire;
      irq_q           <= irq_d;
      active_period_q <= active_period_d;
      pre_q           <= pre_d;
      if (cfg_load) begin
        shadow_period_q   <= cfg_period;
        shadow_periodic_q <= cfg_periodic;
      end
    end
  end

  assign state   = state_q;
  assign busy    = busy_q;
  assign expired = expired_q;
  assign irq     = irq_q;

endmodule

// File: doc/interval_timer_ctrl.md
Name: interval_timer_ctrl

Overview:
Programmable interval timer controller that sequences a 32-bit up-counter datapath (sync clear, enable) through start/pause/stop/expire.
Supports one-shot and periodic modes, with a shadowed period register and a sticky interrupt.
Sits between the register/config interface and the free-running counter, turning the counter into a scheduled timebase for the rest of the design.

Parameters:
- WIDTH, 32, counter and period width in bits.
- PRESCALE_W, 8, prescaler width (used only with the optional feature).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_load  in  1  pulse; loads cfg_period and cfg_periodic into the shadow registers.
- cfg_period  in  WIDTH  terminal period P; expiry every P counted ticks.
- cfg_periodic  in  1  1 = auto-reload, 0 = one-shot.
- start  in  1  pulse; start from IDLE/DONE, resume from PAUSE.
- pause  in  1  pulse; RUN -> PAUSE.
- stop  in  1  pulse; any state -> IDLE, count cleared.
- irq_clr  in  1  pulse; clears irq.
- count  out  WIDTH  current counter value.
- state  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- busy  out  1  high in RUN or PAUSE.
- expired  out  1  registered one-cycle pulse on each expiry.
- irq  out  1  sticky expiry flag.

Behaviour:
- Reset (sync, highest priority): state=IDLE, count=0, expired=0, irq=0, shadow period=0, shadow periodic=0, active period=0.
- Command priority within one cycle: reset > stop > start > pause.
- stop: state<=IDLE, count<=0. No expired pulse; irq is unchanged.
- start in IDLE/DONE with shadow P != 0: active period<=shadow P, count<=0, state<=RUN.
  - The first increment occurs on the next RUN cycle.
  - start with P == 0 is ignored; state stays put.
- start in PAUSE: state<=RUN, count is preserved. start in RUN: ignored.
- pause in RUN: state<=PAUSE, count frozen. pause in any other state: ignored.
- RUN tick, count != P-1: count<=count+1.
- RUN tick, count == P-1: expired<=1 for exactly one cycle and irq<=1.
  - Periodic: count<=0, active period<=shadow P (new period applies only at the wrap).
  - One-shot: state<=DONE, count holds P-1.
- Expiry latency: with start sampled at edge N, the first expiry registers at edge N+P, so expired is high during cycle N+P.
- P == 1: expires on every RUN tick; in periodic mode expired stays high continuously.
- cfg_load: updates the shadow registers only. It never disturbs an in-progress count.
  - In one-shot, the new P takes effect at the next start.
  - cfg_periodic change takes effect immediately on the next expiry decision.
- Coincident irq set and irq_clr in the same cycle: the set wins, so irq=1.
- All arithmetic is modulo 2^WIDTH. With P = 2^WIDTH - 1, count reaches all-ones minus one and then wraps to 0; count never overflows past P-1.
- busy, state and count are registered outputs, valid the cycle after the causing edge.

Optional Feature:
- Macro: INTERVAL_TIMER_PRESCALE_EN.
- Defined:
  - Adds input cfg_prescale [PRESCALE_W].
  - A prescale counter runs only in RUN and issues a tick every (cfg_prescale+1) RUN cycles.
  - The prescale counter clears on start-from-IDLE/DONE, stop, reset and every tick, and freezes in PAUSE.
  - Latency becomes (prescale+1)*P cycles.
- Undefined: the port is absent and every RUN cycle is a tick.

Decomposition:
- Package timer_pkg holds:
  - state enum (IDLE/RUN/PAUSE/DONE) and its 2-bit encoding;
  - default WIDTH and PRESCALE_W constants.
- Sub-module timer_count_core: WIDTH-bit counter with sync reset, sync clear and enable, output count.
- The controller FSM, shadow registers, compare and irq logic live in interval_timer_ctrl.

Test Plan:
- Period 5, one-shot, start at cycle 10 -> count 0..4; expired pulse in cycle 15; state=DONE; count holds 4; irq=1; busy=0.
- Period 3, periodic, run 10 ticks -> expired at ticks 3, 6, 9; count sequence 0,1,2,0,1,2…; irq_clr at tick 7 -> irq low until tick 9.
- Period 8, pause at count 4 for 6 cycles, then start -> count frozen at 4; resume reaches expiry 6 cycles later than the unpaused case.
- Periodic P=4 running; cfg_load P=2 at count 1 -> current period completes at 4; the following periods are 2 ticks.
- stop and start in the same cycle while RUN -> state=IDLE, count=0. start with P=0 -> state stays IDLE.
- Reset asserted mid-RUN at count 6 -> next cycle count=0, state=IDLE, irq=0, expired=0. With INTERVAL_TIMER_PRESCALE_EN and prescale=2, P=2 -> expiry 6 cycles after start.
